// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths and state type for the NN datapath stages
package nn_pkg;
   localparam int ACC_W   = 16;
   localparam int ACT_W   = 8;
   localparam int SHIFT_W = 4;
   localparam int ACT_MAX = 255;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;
endpackage

// File: rtl/requant_relu_serializer_if.sv
// rtl/requant_relu_serializer_if.sv - vector capture and activation stream handshake bundle
interface requant_relu_serializer_if
   import nn_pkg::*;
#(
   parameter int M     = 2,
   parameter int IDX_W = (M > 1) ? $clog2(M) : 1
);
   logic               in_valid;
   logic               in_ready;
   logic [ACC_W-1:0]   y_in [0:M-1];
   logic [SHIFT_W-1:0] shift_amt;
   logic               out_valid;
   logic               out_ready;
   logic [ACT_W-1:0]   out_data;
   logic [IDX_W-1:0]   out_idx;
   logic               out_last;

   modport master (
      output in_valid, y_in, shift_amt, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, y_in, shift_amt, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/requant_relu_serializer_requant_unit.sv
// rtl/requant_relu_serializer_requant_unit.sv - one-element ReLU, shift and saturate; REQUANT_ROUND_EN adds round-half-up
module requant_unit
   import nn_pkg::*;
(
   input  logic [ACC_W-1:0]   acc,
   input  logic [SHIFT_W-1:0] shift,
   output logic [ACT_W-1:0]   act
);
   // Negative inputs are forced to zero below, so the 17-bit path only sees non-negative values.
   logic [ACC_W:0] wide;
   logic [ACC_W:0] shifted;

   always_comb begin
      wide = {1'b0, acc};
`ifdef REQUANT_ROUND_EN
      if (shift != '0) begin
         wide = wide + ((ACC_W+1)'(1) << (shift - 1'b1));
      end
`endif
      shifted = wide >> shift;
      if (acc[ACC_W-1]) begin
         act = '0;
      end else if (shifted > (ACC_W+1)'(ACT_MAX)) begin
         act = ACT_W'(ACT_MAX);
      end else begin
         act = shifted[ACT_W-1:0];
      end
   end
endmodule

// File: rtl/requant_relu_serializer.sv
// rtl/requant_relu_serializer.sv - requantize an accumulator vector and stream it out; REQUANT_ROUND_EN selects rounding
module requant_relu_serializer
   import nn_pkg::*;
#(
   parameter int M     = 2,
   parameter int IDX_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic clk,
   input  logic rst,
   requant_relu_serializer_if.slave bus
);
   state_t           state;
   logic             ready_q;
   logic [IDX_W-1:0] idx;
   logic [ACT_W-1:0] act_buf [0:M-1];
   logic [ACT_W-1:0] act     [0:M-1];
   logic             last_idx;

   for (genvar g = 0; g < M; g++) begin : g_rq
      requant_unit u_rq (
         .acc   (bus.y_in[g]),
         .shift (bus.shift_amt),
         .act   (act[g])
      );
   end

   assign last_idx = (idx == IDX_W'(M - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ready_q <= 1'b0;
         idx     <= '0;
         for (int i = 0; i < M; i++) begin
            act_buf[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (bus.in_valid && ready_q) begin
                  for (int i = 0; i < M; i++) begin
                     act_buf[i] <= act[i];
                  end
                  idx     <= '0;
                  state   <= ST_STREAM;
                  ready_q <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (bus.out_ready) begin
                  if (last_idx) begin
                     state   <= ST_IDLE;
                     ready_q <= 1'b1;
                     idx     <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registers only; out_ready never reaches them combinationally.
   assign bus.in_ready  = ready_q;
   assign bus.out_valid = (state == ST_STREAM);
   assign bus.out_data  = act_buf[idx];
   assign bus.out_idx   = idx;
   assign bus.out_last  = (state == ST_STREAM) && last_idx;
endmodule

// File: tb/tb_requant_relu_serializer.sv
// tb/tb_requant_relu_serializer.sv - randomized self-checking bench with a behavioural requant model
`timescale 1ns/1ps
module tb_requant_relu_serializer;
   localparam int M = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   requant_relu_serializer_if #(.M(M)) bus ();
   requant_relu_serializer_if #(.M(1)) bus1 ();

   requant_relu_serializer #(.M(M)) dut (.clk(clk), .rst(rst), .bus(bus));
   requant_relu_serializer #(.M(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: ReLU, optional round-half-up, divide by 2**sh, clamp to 255.
   function automatic int model(input logic [15:0] v, input logic [3:0] sh);
      int x;
      int r;
      x = int'($signed(v));
      if (x < 0) return 0;
`ifdef REQUANT_ROUND_EN
      if (sh != 0) x = x + (1 << (int'(sh) - 1));
`endif
      r = x / (1 << int'(sh));
      return (r > 255) ? 255 : r;
   endfunction

   task automatic run_vec(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [3:0] sh, input int stall_pct, input bit btb);
      int exp_v [0:M-1];
      int k;
      int cyc;
      exp_v[0] = model(a0, sh);
      exp_v[1] = model(a1, sh);
      cyc = 0;
      while (bus.in_ready !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
      chk("in_ready_wait", int'(bus.in_ready), 1);
      if (btb) chk("btb_gap", cyc, 0);
      bus.in_valid  = 1'b1;
      bus.y_in[0]   = a0;
      bus.y_in[1]   = a1;
      bus.shift_amt = sh;
      step();
      chk("first_valid", int'(bus.out_valid), 1);
      k = 0;
      cyc = 0;
      while (k < M && cyc < 200) begin
         bus.in_valid  = 1'($urandom);
         bus.y_in[0]   = 16'($urandom);
         bus.y_in[1]   = 16'($urandom);
         bus.shift_amt = 4'($urandom);
         bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
         if (bus.out_valid === 1'b1) begin
            chk("out_data", int'(bus.out_data), exp_v[k]);
            chk("out_idx", int'(bus.out_idx), k);
            chk("out_last", int'(bus.out_last), (k == M - 1) ? 1 : 0);
            chk("in_ready_stream", int'(bus.in_ready), 0);
            if (bus.out_ready) k++;
         end else begin
            chk("valid_drop", int'(bus.out_valid), 1);
         end
         step();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("beats", k, M);
      chk("post_valid", int'(bus.out_valid), 0);
      chk("post_ready", int'(bus.in_ready), 1);
   endtask

   initial begin
      logic [15:0] r0;
      logic [15:0] r1;
      int cyc;
      bus.in_valid = 1'b0;  bus.out_ready = 1'b1;  bus.shift_amt = '0;
      bus.y_in[0]  = '0;    bus.y_in[1]   = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.shift_amt = '0;
      bus1.y_in[0]  = '0;
      step();
      step();
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_idx", int'(bus.out_idx), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready_hold", int'(bus.in_ready), 0);
      step();
      chk("rel_in_ready_rise", int'(bus.in_ready), 1);

      run_vec(16'h0123, 16'hFF00, 4'd2, 0, 1'b1);
      run_vec(16'h7FFF, 16'h00FF, 4'd0, 0, 1'b1);
      run_vec(16'h7FFF, 16'h00FF, 4'd1, 0, 1'b1);
      run_vec(16'h0006, 16'h0006, 4'd2, 0, 1'b1);
      run_vec(16'h7FFF, 16'h8000, 4'd15, 0, 1'b1);
      run_vec(16'h00FF, 16'h0100, 4'd0, 60, 1'b0);

      // Abort while idx 0 is still pending.
      bus.in_valid = 1'b1; bus.y_in[0] = 16'h0040; bus.y_in[1] = 16'h0041; bus.shift_amt = 4'd0;
      step();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      step();
      chk("pre_abort_valid", int'(bus.out_valid), 1);
      rst = 1'b1;
      #1;
      chk("abort_valid", int'(bus.out_valid), 0);
      chk("abort_ready", int'(bus.in_ready), 0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      chk("abort_ready_hold", int'(bus.in_ready), 0);
      step();
      chk("abort_ready_rise", int'(bus.in_ready), 1);
      chk("abort_no_beat", int'(bus.out_valid), 0);
      run_vec(16'h0200, 16'h0010, 4'd1, 0, 1'b1);

      for (int i = 0; i < 30; i++) begin
         r0 = 16'($urandom);
         r1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
         run_vec(r0, r1, 4'($urandom), 30, (i % 2) == 0);
      end

      // Single-element configuration.
      bus1.in_valid = 1'b1; bus1.y_in[0] = 16'h0200; bus1.shift_amt = 4'd1;
      step();
      bus1.in_valid = 1'b0;
      chk("m1_valid", int'(bus1.out_valid), 1);
      chk("m1_data", int'(bus1.out_data), model(16'h0200, 4'd1));
      chk("m1_idx", int'(bus1.out_idx), 0);
      chk("m1_last", int'(bus1.out_last), 1);
      step();
      chk("m1_done", int'(bus1.out_valid), 0);
      chk("m1_ready", int'(bus1.in_ready), 1);
      bus1.in_valid = 1'b1; bus1.y_in[0] = 16'h0035; bus1.shift_amt = 4'd2;
      cyc = 0;
      step();
      bus1.in_valid = 1'b0;
      chk("m1_data2", int'(bus1.out_data), model(16'h0035, 4'd2));
      chk("m1_last2", int'(bus1.out_last), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/requant_relu_serializer.md
Name: requant_relu_serializer

Overview:
- Downstream stage of the matrix-vector multiply/accumulate layer.
- Accepts one M-element vector of 16-bit accumulator+bias results per transaction.
- Applies ReLU, arithmetic right-shift requantization and unsigned 8-bit saturation.
- Streams the M 8-bit activations out one per cycle over valid/ready, in the format the next layer's x input consumes.

Parameters:
- M, 2, vector length (rows of the producing layer); must be >= 1.
- IDX_W, $clog2(M) (minimum 1), width of the element index output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer has a valid vector on y_in.
- in_ready  output  1  block can capture a vector this cycle.
- y_in  input  16 x [0:M-1]  accumulator+bias vector, two's-complement signed.
- shift_amt  input  4  right-shift amount; sampled with the vector.
- out_valid  output  1  out_data holds a valid activation.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  8  requantized unsigned activation.
- out_idx  output  IDX_W  element index of out_data, range 0..M-1.
- out_last  output  1  high with the element at index M-1.

Behaviour:
- States: IDLE and STREAM, encoded as a 1-bit enum.
- Reset (async assert, sync release):
  - state=IDLE, in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, buffer cleared.
  - in_ready rises on the first clk edge after rst deasserts.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: requantize all M elements with the sampled shift_amt, write them to the 8-bit buffer, set idx=0, go to STREAM, and drop in_ready on that same edge.
- STREAM:
  - out_valid=1, out_data=buf[idx], out_idx=idx, out_last=(idx==M-1). All are registered or decoded from registers only; no combinational path from input to output.
  - On out_valid&&out_ready with idx<M-1: idx advances by 1.
  - On out_valid&&out_ready with idx==M-1: return to IDLE; out_valid=0 and in_ready=1 on the next cycle.
- Latency:
  - First out_valid is 1 cycle after the capture edge.
  - Throughput is M+1 cycles per vector with out_ready held high.
  - Vectors never overlap.
- Backpressure: while out_ready=0, out_data, out_idx and out_last hold stable; y_in and shift_amt changes are ignored.
- Requantization, per element v (signed 16-bit):
  - If v<0, r=0 (ReLU).
  - Otherwise r = v >>> shift_amt, computed at 17 bits internally.
  - out = (r>255) ? 255 : r[7:0].
  - shift_amt=0 passes the value through before saturation.
- M=1: single beat with out_idx=0 and out_last=1.
- Reset mid-STREAM: aborts immediately. Partially sent vectors are not resumed and no further beats are emitted.
- in_valid while in STREAM: not accepted; the producer must hold it until in_ready.

Optional Feature:
- Macro REQUANT_ROUND_EN.
- Defined: round-half-up before the shift. For shift_amt>0, r = (v + (1<<(shift_amt-1))) >>> shift_amt, using the 17-bit intermediate so there is no overflow. Saturation still applies.
- Undefined: truncating shift only, as above.
- ReLU, handshake and timing are identical in both builds.

Decomposition:
- Shared package nn_pkg:
  - ACC_W=16, ACT_W=8, SHIFT_W=4, ACT_MAX=255.
  - State enum typedef.
  - ACC_W is shared with the multiply/accumulate layer.
- Sub-module requant_unit: combinational, one element (acc, shift -> 8-bit act), holding the ReLU/round/shift/saturate logic; instantiated M times in a generate loop at the capture path.

Test Plan:
- Basic, M=2, shift=2: y_in={16'h0123,16'hFF00}, out_ready=1 -> beats 8'h48 (idx0, last=0), 8'h00 (idx1, last=1); in_ready high the cycle after the last beat.
- Saturation, shift=0: y_in={16'h7FFF,16'h00FF} -> 8'hFF, 8'hFF; with shift=1 -> 8'hFF, 8'h7F.
- Rounding, y=16'h0006, shift=2: macro undefined -> 8'h01; REQUANT_ROUND_EN defined -> 8'h02. Also y=16'h7FFF, shift=1, rounded -> 8'hFF with no wrap.
- Backpressure: out_ready low 3 cycles mid-vector -> out_data/out_idx stable, no skipped or duplicated index; y_in changes during STREAM do not affect output.
- Reset mid-stream: assert rst while idx=0 is pending -> out_valid=0 and in_ready=0 asynchronously; after release in_ready=1 on the next edge and a new vector streams from idx 0.
- Back-to-back: in_valid held high with two vectors -> exactly one idle cycle between the last beat and the next capture; in_ready never high during STREAM.
